operand_skew_feeder: RTL

// - Consumes the 64-bit paired-word stream read out of the operand buffer; each word carries two 32-bit elements.
// - Assembles ROWS elements into one column vector and drives row i of the systolic array delayed i cycles (diagonal skew).
// - Frames a tile of K_DEPTH columns, drains the skew chain, then pulses tile_done. Sits between operand buffer and PE array.

---
 rtl/sys_array_pkg.sv | 16 +
 rtl/skew_delay_line.sv | 44 ++++
 rtl/operand_skew_feeder.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/sys_array_pkg.sv
// Shared constants and the operand feeder state encoding for the systolic array front end.
package sys_array_pkg;

  localparam int unsigned DATA_W          = 32;
  localparam int unsigned PAIR_W          = 64;
  localparam int unsigned DEFAULT_ROWS    = 4;
  localparam int unsigned DEFAULT_K_DEPTH = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GATHER = 2'd1,
    DRAIN  = 2'd2,
    DONE   = 2'd3
  } feeder_state_e;

endpackage

// File: rtl/skew_delay_line.sv
// Data+valid shift register with a common hold enable; DEPTH=0 degenerates to a wire.
module skew_delay_line #(
  parameter int unsigned DEPTH  = 1,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid
);

  if (DEPTH == 0) begin : g_pass
    logic unused_ctrl;
    assign unused_ctrl = ^{clk, reset, en};
    assign out_data    = in_data;
    assign out_valid   = in_valid;
  end else begin : g_shift
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DEPTH-1:0]  valid_q;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        for (int k = 0; k < DEPTH; k++) begin
          data_q[k] <= '0;
        end
        valid_q <= '0;
      end else if (en) begin
        data_q[0]  <= in_data;
        valid_q[0] <= in_valid;
        for (int k = 1; k < DEPTH; k++) begin
          data_q[k]  <= data_q[k-1];
          valid_q[k] <= valid_q[k-1];
        end
      end
    end

    assign out_data  = data_q[DEPTH-1];
    assign out_valid = valid_q[DEPTH-1];
  end

endmodule

// File: rtl/operand_skew_feeder.sv
// Gathers paired operand words into column vectors and feeds the PE array rows with a
// diagonal skew, framing K_DEPTH columns per tile followed by a drain of the skew chain.
module operand_skew_feeder #(
  parameter int unsigned DATA_W  = sys_array_pkg::DATA_W,
  parameter int unsigned ROWS    = sys_array_pkg::DEFAULT_ROWS,
  parameter int unsigned K_DEPTH = sys_array_pkg::DEFAULT_K_DEPTH
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              start,
  input  logic [sys_array_pkg::PAIR_W-1:0]  in_data,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic                              array_stall,
  output logic [ROWS*DATA_W-1:0]            row_data,
  output logic [ROWS-1:0]                   row_valid,
  output logic                              busy,
  output logic                              tile_done
);

  import sys_array_pkg::PAIR_W;
  import sys_array_pkg::feeder_state_e;
  import sys_array_pkg::IDLE;
  import sys_array_pkg::GATHER;
  import sys_array_pkg::DRAIN;
  import sys_array_pkg::DONE;

  localparam int unsigned WORDS    = ROWS / 2;
  localparam int unsigned WIDX_W   = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int unsigned COL_W    = (K_DEPTH > 1) ? $clog2(K_DEPTH) : 1;
  localparam int unsigned DRN_W    = $clog2(ROWS);
  localparam int unsigned GATHER_W = (ROWS > 2) ? (ROWS - 2) * DATA_W : DATA_W;

  localparam logic [WIDX_W-1:0] LAST_WORD = WIDX_W'(WORDS - 1);
  localparam logic [COL_W-1:0]  LAST_COL  = COL_W'(K_DEPTH - 1);
  localparam logic [DRN_W-1:0]  LAST_DRN  = DRN_W'(ROWS - 2);

  feeder_state_e         state_q, state_d;
  logic [WIDX_W-1:0]     word_idx_q, word_idx_d;
  logic [COL_W-1:0]      col_q, col_d;
  logic [DRN_W-1:0]      drn_q, drn_d;
  logic [GATHER_W-1:0]   gather_q, gather_d;

  logic                  advance;
  logic                  accept;
  logic                  launch;
  logic [DATA_W-1:0]     elem_hi;
  logic [DATA_W-1:0]     elem_lo;
  logic [ROWS*DATA_W-1:0] col_vec;
  logic [ROWS*DATA_W-1:0] lane_in_data;
  logic [ROWS*DATA_W-1:0] lane_out_data;
  logic [ROWS-1:0]        lane_out_valid;
  logic [ROWS*DATA_W-1:0] row_data_q;
  logic [ROWS-1:0]        row_valid_q;

  // A stalled array freezes every register in the block, so one enable gates them all.
  assign advance  = !array_stall;
  assign in_ready = (state_q == GATHER) && advance;
  assign accept   = in_valid && in_ready;
  assign launch   = accept && (word_idx_q == LAST_WORD);

  assign elem_hi = in_data[PAIR_W-1 -: DATA_W];
  assign elem_lo = in_data[DATA_W-1:0];

  // Last word of a column bypasses the gather register and joins the buffered elements.
  if (ROWS > 2) begin : g_col_gather
    assign col_vec = {elem_lo, elem_hi, gather_q};
  end else begin : g_col_direct
    assign col_vec = {elem_lo, elem_hi};
  end

  assign lane_in_data = launch ? col_vec : '0;

  always_comb begin
    state_d    = state_q;
    word_idx_d = word_idx_q;
    col_d      = col_q;
    drn_d      = drn_q;
    gather_d   = gather_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = GATHER;
        end
      end
      GATHER: begin
        if (accept) begin
          if (launch) begin
            word_idx_d = '0;
            if (col_q == LAST_COL) begin
              col_d   = '0;
              state_d = DRAIN;
            end else begin
              col_d = col_q + 1'b1;
            end
          end else begin
            word_idx_d = word_idx_q + 1'b1;
          end
        end
      end
      DRAIN: begin
        if (drn_q == LAST_DRN) begin
          drn_d   = '0;
          state_d = DONE;
        end else begin
          drn_d = drn_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    for (int j = 0; j + 1 < WORDS; j++) begin
      if (accept && !launch && (word_idx_q == WIDX_W'(j))) begin
        gather_d[(2 * j) * DATA_W +: DATA_W]     = elem_hi;
        gather_d[(2 * j + 1) * DATA_W +: DATA_W] = elem_lo;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      word_idx_q <= '0;
      col_q      <= '0;
      drn_q      <= '0;
      gather_q   <= '0;
    end else if (advance) begin
      state_q    <= state_d;
      word_idx_q <= word_idx_d;
      col_q      <= col_d;
      drn_q      <= drn_d;
      gather_q   <= gather_d;
    end
  end

  // Row i sits behind i extra stages, producing the diagonal wavefront.
  for (genvar i = 0; i < ROWS; i++) begin : g_lane
    skew_delay_line #(
      .DEPTH  (i),
      .DATA_W (DATA_W)
    ) u_lane (
      .clk       (clk),
      .reset     (reset),
      .en        (advance),
      .in_data   (lane_in_data[i*DATA_W +: DATA_W]),
      .in_valid  (launch),
      .out_data  (lane_out_data[i*DATA_W +: DATA_W]),
      .out_valid (lane_out_valid[i])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row_data_q  <= '0;
      row_valid_q <= '0;
    end else if (advance) begin
      row_data_q  <= lane_out_data;
      row_valid_q <= lane_out_valid;
    end
  end

  assign row_data  = row_data_q;
  assign row_valid = row_valid_q;
  assign busy      = (state_q != IDLE);
  assign tile_done = (state_q == DONE);

endmodule
